// File: rtl/mc_pkg.sv
// Shared definitions for the matmul_core engine: FSM state encoding and
// default elaboration constants.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RD_A  = 3'd2,
    ST_RD_B  = 3'd3,
    ST_WR_C  = 3'd4,
    ST_DONE  = 3'd5
  } mc_state_e;

  localparam int MC_WIDTH     = 8;
  localparam int MC_ADDR_W    = 8;
  localparam int MC_DIM_W     = 8;
  localparam int MC_NUM_CORES = 4;
  localparam int MC_CID_W     = 3;

endpackage

// File: rtl/mc_addr_gen.sv
// DRAM address generator: maps the FSM state and loop indices to the
// row-major element address of A, B or C. Arithmetic is done wide enough
// for the full index product and then truncated, so addresses wrap.
module mc_addr_gen
  import mc_pkg::*;
#(
  parameter int ADDR_W = MC_ADDR_W,
  parameter int DIM_W  = MC_DIM_W
) (
  input  mc_state_e         state,
  input  logic [DIM_W:0]    row_i,
  input  logic [DIM_W-1:0]  col_j,
  input  logic [DIM_W-1:0]  idx_k,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic [ADDR_W-1:0] addr
);

  localparam int PW = 2 * DIM_W + 1;
  localparam int SW = (PW > ADDR_W) ? PW : ADDR_W;

  logic [SW-1:0] sum_s;

  // Select the matrix being addressed and form base + row*stride + col.
  always_comb begin
    sum_s = {SW{1'b0}};
    case (state)
      ST_RD_A: sum_s = SW'(base_a) + SW'(row_i) * SW'(dim_k) + SW'(idx_k);
      ST_RD_B: sum_s = SW'(base_b) + SW'(idx_k) * SW'(dim_n) + SW'(col_j);
      ST_WR_C: sum_s = SW'(base_c) + SW'(row_i) * SW'(dim_n) + SW'(col_j);
      default: sum_s = {SW{1'b0}};
    endcase
  end

  assign addr = sum_s[ADDR_W-1:0];

endmodule

// File: rtl/matmul_core.sv
// Self-sequencing integer matrix-multiply core. Computes the rows
// coreID, coreID+NUM_CORES, ... of C = A x B through a request/grant
// DRAM port. All outputs are registered from next-state values.
module matmul_core
  import mc_pkg::*;
#(
  parameter int WIDTH     = MC_WIDTH,
  parameter int ADDR_W    = MC_ADDR_W,
  parameter int DIM_W     = MC_DIM_W,
  parameter int NUM_CORES = MC_NUM_CORES,
  parameter int CID_W     = MC_CID_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  dimM,
  input  logic [DIM_W-1:0]  dimK,
  input  logic [DIM_W-1:0]  dimN,
  input  logic [ADDR_W-1:0] baseA,
  input  logic [ADDR_W-1:0] baseB,
  input  logic [ADDR_W-1:0] baseC,
  input  logic [CID_W-1:0]  coreID,
  input  logic              memAV,
  input  logic [WIDTH-1:0]  DRAM_dataIn,
  output logic [ADDR_W-1:0] DRAM_addr,
  output logic [WIDTH-1:0]  DRAM_dataOut,
  output logic              memREAD,
  output logic              memWRITE,
  output logic              coreS,
  output logic              nextLoop,
  output logic              done
);

  localparam logic [DIM_W:0] ROW_STEP = (DIM_W+1)'(NUM_CORES);

  mc_state_e         state_q, state_d;
  logic [DIM_W:0]    i_q, i_d, i_step_s;
  logic [DIM_W-1:0]  j_q, j_d, k_q, k_d;
  logic [DIM_W:0]    j_next_s, k_next_s;
  logic [WIDTH-1:0]  acc_q, acc_d, a_q, a_d;
  logic [DIM_W-1:0]  dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;
  logic [ADDR_W-1:0] base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
  logic [ADDR_W-1:0] addr_q, addr_s;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              rd_q, rd_d, wr_q, wr_d, busy_q, busy_d;
  logic              nl_q, nl_d, done_q, done_d;
  logic              k_zero_s;

  mc_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_addr_gen (
    .state  (state_d),
    .row_i  (i_d),
    .col_j  (j_d),
    .idx_k  (k_d),
    .dim_k  (dim_k_d),
    .dim_n  (dim_n_d),
    .base_a (base_a_d),
    .base_b (base_b_d),
    .base_c (base_c_d),
    .addr   (addr_s)
  );

  // Next-state, loop-index and datapath computation; outputs derive from next state.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    a_d      = a_q;
    dim_m_d  = dim_m_q;
    dim_k_d  = dim_k_q;
    dim_n_d  = dim_n_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    base_c_d = base_c_q;
    nl_d     = 1'b0;
    k_next_s = {1'b0, k_q} + {{DIM_W{1'b0}}, 1'b1};
    j_next_s = {1'b0, j_q} + {{DIM_W{1'b0}}, 1'b1};
    i_step_s = i_q + ROW_STEP;
    k_zero_s = (dim_k_q == {DIM_W{1'b0}});
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETUP;
          dim_m_d  = dimM;
          dim_k_d  = dimK;
          dim_n_d  = dimN;
          base_a_d = baseA;
          base_b_d = baseB;
          base_c_d = baseC;
          i_d      = (DIM_W+1)'(coreID);
          j_d      = {DIM_W{1'b0}};
          k_d      = {DIM_W{1'b0}};
          acc_d    = {WIDTH{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if ((i_q >= {1'b0, dim_m_q}) || (dim_n_q == {DIM_W{1'b0}})) begin
          state_d = ST_DONE;
        end else if (k_zero_s) begin
          state_d = ST_WR_C;
        end else begin
          state_d = ST_RD_A;
        end
      end
      ST_RD_A: begin
        if (memAV) begin
          a_d     = DRAM_dataIn;
          state_d = ST_RD_B;
        end else begin
          state_d = ST_RD_A;
        end
      end
      ST_RD_B: begin
        if (memAV) begin
          acc_d = acc_q + a_q * DRAM_dataIn;
          k_d   = k_next_s[DIM_W-1:0];
          if (k_next_s == {1'b0, dim_k_q}) begin
            state_d = ST_WR_C;
          end else begin
            state_d = ST_RD_A;
          end
        end else begin
          state_d = ST_RD_B;
        end
      end
      ST_WR_C: begin
        if (memAV) begin
          acc_d = {WIDTH{1'b0}};
          k_d   = {DIM_W{1'b0}};
          if (j_next_s == {1'b0, dim_n_q}) begin
            j_d  = {DIM_W{1'b0}};
            i_d  = i_step_s;
            nl_d = 1'b1;
            if (i_step_s >= {1'b0, dim_m_q}) begin
              state_d = ST_DONE;
            end else if (k_zero_s) begin
              state_d = ST_WR_C;
            end else begin
              state_d = ST_RD_A;
            end
          end else begin
            j_d = j_next_s[DIM_W-1:0];
            if (k_zero_s) begin
              state_d = ST_WR_C;
            end else begin
              state_d = ST_RD_A;
            end
          end
        end else begin
          state_d = ST_WR_C;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    rd_d   = (state_d == ST_RD_A) || (state_d == ST_RD_B);
    wr_d   = (state_d == ST_WR_C);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    dout_d = wr_d ? acc_d : dout_q;
  end

  // State and output registers with synchronous reset that aborts any job.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      i_q      <= {(DIM_W+1){1'b0}};
      j_q      <= {DIM_W{1'b0}};
      k_q      <= {DIM_W{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      a_q      <= {WIDTH{1'b0}};
      dim_m_q  <= {DIM_W{1'b0}};
      dim_k_q  <= {DIM_W{1'b0}};
      dim_n_q  <= {DIM_W{1'b0}};
      base_a_q <= {ADDR_W{1'b0}};
      base_b_q <= {ADDR_W{1'b0}};
      base_c_q <= {ADDR_W{1'b0}};
      addr_q   <= {ADDR_W{1'b0}};
      dout_q   <= {WIDTH{1'b0}};
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      nl_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      dim_m_q  <= dim_m_d;
      dim_k_q  <= dim_k_d;
      dim_n_q  <= dim_n_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_c_q <= base_c_d;
      addr_q   <= addr_s;
      dout_q   <= dout_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      nl_q     <= nl_d;
      done_q   <= done_d;
    end
  end

  assign DRAM_addr    = addr_q;
  assign DRAM_dataOut = dout_q;
  assign memREAD      = rd_q;
  assign memWRITE     = wr_q;
  assign coreS        = busy_q;
  assign nextLoop     = nl_q;
  assign done         = done_q;

endmodule
